// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder controller.
//   sa_state_t        : controller state encoding (IDLE, RUN, DONE)
//   SA_DEFAULT_WIDTH  : default operand / sum width in bits
// ---------------------------------------------------------------------------
package serial_adder_pkg;

   localparam int SA_DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sa_state_t;

endpackage

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// One-bit combinational full adder cell, shared by the serial controller.
// Ports:
//   a, b  : addend bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out
// ---------------------------------------------------------------------------
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial adder: one full_adder cell is reused over WIDTH clocks, LSB
// first, to form {cout, sum} = a + b + cin. Operands live in shift
// registers, the running carry in a flop; results are registered and held
// until the next accepted start.
//
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous, active-high reset
//   start  : request, sampled only in IDLE
//   a, b   : WIDTH-bit operands, captured on an accepted start
//   cin    : carry in, captured on an accepted start
//   busy   : high whenever the controller is not IDLE
//   done   : one-cycle pulse, result valid
//   sum    : registered WIDTH-bit sum
//   cout   : registered unsigned carry out
//   ovf    : registered two's-complement overflow
//            (only when SERIAL_ADDER_OVF_EN is defined)
//
// Optional feature macro: SERIAL_ADDER_OVF_EN
// ---------------------------------------------------------------------------
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = SA_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = $clog2(WIDTH);

   sa_state_t        state;
   sa_state_t        state_next;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   // Holds the bits produced so far, minus the MSB that is still to come;
   // the bit produced on the last RUN cycle completes the word directly.
   logic [WIDTH-2:0] sum_sr;
   logic             carry;
   logic [CNT_W-1:0] cnt;

   logic             fa_s;
   logic             fa_cout;
   logic             last_bit;
   logic [WIDTH-1:0] sum_next;

   full_adder full_adder_0 (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_cout)
   );

   assign last_bit = (cnt == CNT_W'(WIDTH - 1));
   assign sum_next = {fa_s, sum_sr};

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last_bit) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs decoded purely from the state register
   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   // Datapath: operand capture, per-bit shifting and result registration.
   // The counter is held on the last bit so it never wraps mid-operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum    <= '0;
         cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  carry  <= cin;
                  sum_sr <= '0;
                  cnt    <= '0;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               sum_sr <= sum_next[WIDTH-1:1];
               carry  <= fa_cout;
               if (last_bit) begin
                  sum  <= sum_next;
                  cout <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                  // carry into the MSB is the current carry flop
                  ovf  <= carry ^ fa_cout;
`endif
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
// Self-checking bench for serial_adder_ctrl (WIDTH=8). Expected results are
// computed from the operands when a request is issued and queued; a monitor
// pops and compares them whenever done pulses. Scenario tasks check timing
// and handshake behaviour inline.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

   localparam int WIDTH = 8;

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf;
`endif

   int   total      = 0;
   int   bad        = 0;
   int   done_count = 0;
   exp_t sb[$];
   exp_t mon_e;

   serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: every done pulse must match the oldest pending result
   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_count++;
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_done: got done=1 required no pending result");
         end else begin
            mon_e = sb.pop_front();
            if (sum !== mon_e.sum) begin
               bad++;
               $display("[TB] FAIL result_sum: got %h required %h", sum, mon_e.sum);
            end
            total++;
            if (cout !== mon_e.cout) begin
               bad++;
               $display("[TB] FAIL result_cout: got %b required %b", cout, mon_e.cout);
            end
`ifdef SERIAL_ADDER_OVF_EN
            total++;
            if (ovf !== mon_e.ovf) begin
               bad++;
               $display("[TB] FAIL result_ovf: got %b required %b", ovf, mon_e.ovf);
            end
`endif
         end
      end
   end

   task automatic push_expected(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                input logic c);
      logic [WIDTH:0] full;
      exp_t           e;
      full   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
      e.sum  = full[WIDTH-1:0];
      e.cout = full[WIDTH];
      e.ovf  = (x[WIDTH-1] == y[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
      sb.push_back(e);
   endtask

   // Drive one request while IDLE; returns #1 after the accepting edge with
   // the operand inputs scrambled so only the captured copies can matter.
   task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic c, input bit expect_result);
      @(negedge clk);
      a     = x;
      b     = y;
      cin   = c;
      start = 1'b1;
      if (expect_result) push_expected(x, y, c);
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      cin   = 1'($urandom);
   endtask

   task automatic wait_done(output int edges);
      edges = 0;
      while (done !== 1'b1 && edges < 40) begin
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b1;
      a     = 8'hA5;
      b     = 8'h5A;
      cin   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_busy: got %b required 0", busy);
      end
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_done: got %b required 0", done);
      end
      total++;
      if (sum !== 8'h00) begin
         bad++;
         $display("[TB] FAIL reset_sum: got %h required 00", sum);
      end
      total++;
      if (cout !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_cout: got %b required 0", cout);
      end
`ifdef SERIAL_ADDER_OVF_EN
      total++;
      if (ovf !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_ovf: got %b required 0", ovf);
      end
`endif
      start = 1'b0;
      rst   = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_idle: got busy=%b required 0", busy);
      end
   endtask

   task automatic test_basic();
      int n;
      issue(8'h5A, 8'h3C, 1'b0, 1'b1);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL basic_busy: got %b required 1", busy);
      end
      wait_done(n);
      total++;
      if (n != WIDTH) begin
         bad++;
         $display("[TB] FAIL basic_latency: got %0d edges required %0d", n, WIDTH);
      end
      @(posedge clk);
      #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL basic_after_done: got done=%b busy=%b required 0 0", done, busy);
      end
   endtask

   task automatic test_carry();
      int n;
      issue(8'hFF, 8'h01, 1'b0, 1'b1);
      wait_done(n);
      repeat (6) @(posedge clk);
      #1;
      total++;
      if (sum !== 8'h00 || cout !== 1'b1) begin
         bad++;
         $display("[TB] FAIL carry_held: got sum=%h cout=%b required 00 1", sum, cout);
      end
   endtask

   task automatic test_cin();
      int n;
      issue(8'h00, 8'h00, 1'b1, 1'b1);
      wait_done(n);
      total++;
      if (n != WIDTH) begin
         bad++;
         $display("[TB] FAIL cin_latency: got %0d edges required %0d", n, WIDTH);
      end
      @(posedge clk);
      #1;
      issue(8'h80, 8'h80, 1'b0, 1'b1);
      wait_done(n);
      @(posedge clk);
      #1;
   endtask

   task automatic test_ignored_start();
      int n;
      int base;
      issue(8'h11, 8'h22, 1'b0, 1'b1);
      base = done_count;
      repeat (2) @(posedge clk);
      #1;
      a     = 8'hAA;
      b     = 8'h55;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(n);
      total++;
      if (n != WIDTH - 3) begin
         bad++;
         $display("[TB] FAIL ignore_latency: got %0d edges required %0d", n, WIDTH - 3);
      end
      a     = 8'h01;
      b     = 8'h01;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL ignore_done_start: got busy=%b required 0", busy);
      end
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b0 || sum !== 8'h33) begin
         bad++;
         $display("[TB] FAIL ignore_held: got busy=%b sum=%h required 0 33", busy, sum);
      end
      total++;
      if (done_count != base + 1) begin
         bad++;
         $display("[TB] FAIL ignore_done_count: got %0d required %0d", done_count, base + 1);
      end
      issue(8'h40, 8'h02, 1'b0, 1'b1);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL ignore_next_accept: got busy=%b required 1", busy);
      end
      wait_done(n);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_abort();
      int n;
      int base;
      base = done_count;
      issue(8'h77, 8'h11, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("[TB] FAIL abort_ctrl: got busy=%b done=%b required 0 0", busy, done);
      end
      total++;
      if (sum !== 8'h00 || cout !== 1'b0) begin
         bad++;
         $display("[TB] FAIL abort_result: got sum=%h cout=%b required 00 0", sum, cout);
      end
      repeat (12) @(posedge clk);
      #1;
      total++;
      if (done_count != base) begin
         bad++;
         $display("[TB] FAIL abort_no_done: got %0d pulses required %0d", done_count, base);
      end
      issue(8'h12, 8'h34, 1'b0, 1'b1);
      wait_done(n);
      total++;
      if (n != WIDTH) begin
         bad++;
         $display("[TB] FAIL abort_recover_latency: got %0d required %0d", n, WIDTH);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      int done_at[$];
      int busy_low;
      busy_low = 0;
      @(negedge clk);
      a     = 8'h0F;
      b     = 8'h01;
      cin   = 1'b0;
      start = 1'b1;
      repeat (3) push_expected(8'h0F, 8'h01, 1'b0);
      @(posedge clk);
      #1;
      for (int k = 1; k <= 29; k++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) done_at.push_back(k);
         if (busy !== 1'b1) busy_low++;
      end
      start = 1'b0;
      total++;
      if (done_at.size() != 3) begin
         bad++;
         $display("[TB] FAIL b2b_done_count: got %0d required 3", done_at.size());
      end else begin
         total++;
         if (done_at[0] != WIDTH || done_at[1] - done_at[0] != 10 ||
             done_at[2] - done_at[1] != 10) begin
            bad++;
            $display("[TB] FAIL b2b_spacing: got %0d,%0d,%0d required 8,18,28",
                     done_at[0], done_at[1], done_at[2]);
         end
      end
      total++;
      if (busy_low != 3) begin
         bad++;
         $display("[TB] FAIL b2b_busy_low: got %0d cycles required 3", busy_low);
      end
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL b2b_release: got busy=%b required 0", busy);
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      $display("[TB] starting serial_adder_ctrl bench");
      test_reset();
      test_basic();
      test_carry();
      test_cin();
      test_ignored_start();
      test_reset_abort();
      test_back_to_back();
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending required 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
